// File: rtl/pipe_stage_skid_if.sv
// pipe_stage_skid_if: upstream/downstream valid-ready bundle for one pipeline stage
interface pipe_stage_skid_if #(
    parameter int CTRL_W    = 16,
    parameter int DATA_W    = 192,
    parameter int IMM_IN_W  = 32,
    parameter int IMM_OUT_W = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CTRL_W-1:0]    in_ctrl;
    logic [DATA_W-1:0]    in_data;
    logic [IMM_IN_W-1:0]  in_imm;
    logic                 out_valid;
    logic                 out_ready;
    logic [CTRL_W-1:0]    out_ctrl;
    logic [DATA_W-1:0]    out_data;
    logic [IMM_OUT_W-1:0] out_imm;

    modport master (
        output in_valid, in_ctrl, in_data, in_imm, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, out_imm
    );

    modport slave (
        input  in_valid, in_ctrl, in_data, in_imm, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, out_imm
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: pipeline stage register with 2-entry skid buffer, flush bubble; PIPE_STAGE_PERF_EN adds stall/flush counters
module pipe_stage_skid #(
    parameter int CTRL_W    = 16,
    parameter int DATA_W    = 192,
    parameter int IMM_IN_W  = 32,
    parameter int IMM_OUT_W = 64
) (
    input logic              clk,
    input logic              rst,
    input logic              flush_i,
    pipe_stage_skid_if.slave bus
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]      stall_cnt_o,
    output logic [15:0]      flush_cnt_o
`endif
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_e;

    state_e               state_q, state_d;
    logic [CTRL_W-1:0]    main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]    main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [IMM_OUT_W-1:0] main_imm_q, main_imm_d, skid_imm_q, skid_imm_d;
    logic [IMM_OUT_W-1:0] imm_ext;
    logic                 accept, drain;

    assign imm_ext       = IMM_OUT_W'($signed(bus.in_imm));
    assign bus.in_ready  = state_q != SKID;
    assign bus.out_valid = state_q != EMPTY;
    assign bus.out_ctrl  = main_ctrl_q;
    assign bus.out_data  = main_data_q;
    assign bus.out_imm   = main_imm_q;
    assign accept        = bus.in_valid & bus.in_ready;
    assign drain         = bus.out_valid & bus.out_ready;

    // next state and register loads; flush overrides everything and clears only control
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        main_imm_d  = main_imm_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        skid_imm_d  = skid_imm_q;
        if (flush_i) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            case (state_q)
                EMPTY: if (accept) begin
                    state_d     = FULL;
                    main_ctrl_d = bus.in_ctrl;
                    main_data_d = bus.in_data;
                    main_imm_d  = imm_ext;
                end
                FULL: if (accept && drain) begin
                    main_ctrl_d = bus.in_ctrl;
                    main_data_d = bus.in_data;
                    main_imm_d  = imm_ext;
                end else if (accept) begin
                    state_d     = SKID;
                    skid_ctrl_d = bus.in_ctrl;
                    skid_data_d = bus.in_data;
                    skid_imm_d  = imm_ext;
                end else if (drain) begin
                    state_d = EMPTY;
                end
                SKID: if (drain) begin
                    state_d     = FULL;
                    main_ctrl_d = skid_ctrl_q;
                    main_data_d = skid_data_q;
                    main_imm_d  = skid_imm_q;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // state and storage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            main_imm_q  <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_imm_q  <= '0;
        end else begin
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            main_imm_q  <= main_imm_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_imm_q  <= skid_imm_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

    // saturating stall and flush event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (bus.out_valid && !bus.out_ready && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_i && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end
`endif
endmodule
